// File: rtl/cu_pkg.sv
// Shared types and constants for the control unit: FSM states, opcodes,
// select and function encodings, and the packed control word.
// Pure definitions; no timing or flow control.
package cu_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        FETCH_L = 3'd1,
        FETCH_H = 3'd2,
        EXEC    = 3'd3,
        HLT     = 3'd4
    } state_t;

    localparam logic [3:0] OP_LDI = 4'h0;
    localparam logic [3:0] OP_LDM = 4'h1;
    localparam logic [3:0] OP_STM = 4'h2;
    localparam logic [3:0] OP_ALU = 4'h3;
    localparam logic [3:0] OP_INC = 4'h4;
    localparam logic [3:0] OP_DEC = 4'h5;
    localparam logic [3:0] OP_MVA = 4'h6;
    localparam logic [3:0] OP_BRA = 4'h7;
    localparam logic [3:0] OP_BEQ = 4'h8;
    localparam logic [3:0] OP_BNE = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ARF read selects
    localparam logic [1:0] SEL_AR  = 2'b00;
    localparam logic [1:0] SEL_SP  = 2'b01;
    localparam logic [1:0] SEL_PCP = 2'b10;
    localparam logic [1:0] SEL_PC  = 2'b11;

    // register function selects
    localparam logic [1:0] FS_CLR = 2'b00;
    localparam logic [1:0] FS_LD  = 2'b01;
    localparam logic [1:0] FS_DEC = 2'b10;
    localparam logic [1:0] FS_INC = 2'b11;

    // MUX A/B sources
    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IMM = 2'b10;
    localparam logic [1:0] MUX_ARF = 2'b11;

    typedef struct packed {
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] funsel_ir;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] funsel_alu;
        logic [3:0] regsel_rf;
        logic [3:0] regsel_arf;
        logic [3:0] rf_tsel;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic       ir_enable;
        logic       ir_lh;
        logic       wr_mem;
        logic       cs_mem;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
        logic       halted;
    } ctrl_t;

    // Control word under which the datapath does nothing observable.
    function automatic ctrl_t idle_ctrl();
        ctrl_t c;
        c            = '0;
        c.funsel_ir  = FS_LD;
        c.funsel_arf = FS_LD;
        c.funsel_rf  = FS_LD;
        c.cs_mem     = 1'b1;
        return c;
    endfunction

    // Rn -> one-hot register enable (bit3 = R1 ... bit0 = R4)
    function automatic logic [3:0] reg_onehot(input logic [1:0] n);
        return 4'b1000 >> n;
    endfunction

    // Rn -> RF read select
    function automatic logic [2:0] reg_osel(input logic [1:0] n);
        return {1'b1, n};
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Instruction decoder: maps opcode, register fields and Z flag to the EXEC control word.
// Purely combinational, zero latency.
// No backpressure; output is valid whenever the inputs are.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [1:0] x,
    input  logic [1:0] y,
    input  logic [3:0] alu_f,
    input  logic       z_flag,
    output ctrl_t      ctrl,
    output logic       is_hlt
);

    logic take_branch;

    // Decode one instruction into its single-cycle control word.
    always_comb begin
        ctrl        = idle_ctrl();
        is_hlt      = 1'b0;
        take_branch = 1'b0;
        case (op)
            OP_LDI: begin
                ctrl.mux_a     = MUX_IMM;
                ctrl.regsel_rf = reg_onehot(x);
                ctrl.funsel_rf = FS_LD;
            end
            OP_LDM: begin
                ctrl.outbsel   = SEL_AR;
                ctrl.cs_mem    = 1'b0;
                ctrl.mux_a     = MUX_MEM;
                ctrl.regsel_rf = reg_onehot(x);
                ctrl.funsel_rf = FS_LD;
            end
            OP_STM: begin
                ctrl.rf_o1sel   = reg_osel(x);
                ctrl.mux_c      = 1'b0;
                ctrl.funsel_alu = 4'b0000;
                ctrl.outbsel    = SEL_AR;
                ctrl.cs_mem     = 1'b0;
                ctrl.wr_mem     = 1'b1;
            end
            OP_ALU: begin
                ctrl.rf_o1sel   = reg_osel(x);
                ctrl.rf_o2sel   = reg_osel(y);
                ctrl.mux_c      = 1'b0;
                ctrl.funsel_alu = alu_f;
                ctrl.mux_a      = MUX_ALU;
                ctrl.regsel_rf  = reg_onehot(x);
                ctrl.funsel_rf  = FS_LD;
            end
            OP_INC: begin
                ctrl.regsel_rf = reg_onehot(x);
                ctrl.funsel_rf = FS_INC;
            end
            OP_DEC: begin
                ctrl.regsel_rf = reg_onehot(x);
                ctrl.funsel_rf = FS_DEC;
            end
            OP_MVA: begin
                // Rx passes through ALU (pass A) onto MUX B into AR
                ctrl.rf_o1sel   = reg_osel(x);
                ctrl.mux_c      = 1'b0;
                ctrl.funsel_alu = 4'b0000;
                ctrl.mux_b      = MUX_ALU;
                ctrl.regsel_arf = 4'b1000;
                ctrl.funsel_arf = FS_LD;
            end
            OP_BRA: take_branch = 1'b1;
            OP_BEQ: take_branch = z_flag;
            OP_BNE: take_branch = !z_flag;
            OP_HLT: is_hlt = 1'b1;
            default: ;
        endcase
        if (take_branch) begin
            ctrl.mux_b      = MUX_IMM;
            ctrl.regsel_arf = 4'b0001;
            ctrl.funsel_arf = FS_LD;
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired sequencer: fetches two IR bytes from M[PC], then executes in one cycle.
// Latency 3 cycles per instruction (FETCH_L, FETCH_H, EXEC); outputs are combinational.
// No backpressure; the datapath always accepts. Reset forces idle outputs and INIT.
module control_unit
    import cu_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] ir_out,
    input  logic [3:0]  flags,
    output logic [1:0]  outasel,
    output logic [1:0]  outbsel,
    output logic [1:0]  funsel_IR,
    output logic [1:0]  funsel_arf,
    output logic [1:0]  funsel_rf,
    output logic [3:0]  funsel_alu,
    output logic [3:0]  regsel_rf,
    output logic [3:0]  regsel_arf,
    output logic [3:0]  rf_tsel,
    output logic [2:0]  rf_o1sel,
    output logic [2:0]  rf_o2sel,
    output logic        IR_enable,
    output logic        IR_lh,
    output logic        wrMEM,
    output logic        csMEM,
    output logic [1:0]  MUXSelA,
    output logic [1:0]  MUXSelB,
    output logic        MUXSelC,
    output logic        halted
);

    state_t state, state_nxt;
    ctrl_t  dec_ctrl, ctrl;
    logic   dec_hlt;

    // Low immediate nibble and C/N/O flags do not affect control.
    logic unused_bits;
    assign unused_bits = ^{ir_out[3:0], flags[2:0]};

    cu_decoder u_dec (
        .op     (ir_out[15:12]),
        .x      (ir_out[11:10]),
        .y      (ir_out[9:8]),
        .alu_f  (ir_out[7:4]),
        .z_flag (flags[3]),
        .ctrl   (dec_ctrl),
        .is_hlt (dec_hlt)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= INIT;
        else          state <= state_nxt;
    end

    // Next state and control word; reset overrides everything with idle.
    always_comb begin
        state_nxt = state;
        ctrl      = idle_ctrl();
        case (state)
            INIT: begin
                state_nxt       = FETCH_L;
                ctrl.regsel_arf = 4'b1111;
                ctrl.regsel_rf  = 4'b1111;
                ctrl.rf_tsel    = 4'b1111;
                ctrl.funsel_arf = FS_CLR;
                ctrl.funsel_rf  = FS_CLR;
                ctrl.ir_enable  = 1'b1;
                ctrl.funsel_ir  = FS_CLR;
            end
            FETCH_L, FETCH_H: begin
                state_nxt       = (state == FETCH_L) ? FETCH_H : EXEC;
                ctrl.outbsel    = SEL_PC;
                ctrl.cs_mem     = 1'b0;
                ctrl.ir_enable  = 1'b1;
                ctrl.ir_lh      = (state == FETCH_H);
                ctrl.funsel_ir  = FS_LD;
                ctrl.regsel_arf = 4'b0001;
                ctrl.funsel_arf = FS_INC;
            end
            EXEC: begin
                state_nxt = dec_hlt ? HLT : FETCH_L;
                ctrl      = dec_ctrl;
            end
            HLT: begin
                state_nxt   = HLT;
                ctrl.halted = 1'b1;
            end
            default: state_nxt = INIT;
        endcase
        if (!reset_n) ctrl = idle_ctrl();
    end

    assign outasel    = ctrl.outasel;
    assign outbsel    = ctrl.outbsel;
    assign funsel_IR  = ctrl.funsel_ir;
    assign funsel_arf = ctrl.funsel_arf;
    assign funsel_rf  = ctrl.funsel_rf;
    assign funsel_alu = ctrl.funsel_alu;
    assign regsel_rf  = ctrl.regsel_rf;
    assign regsel_arf = ctrl.regsel_arf;
    assign rf_tsel    = ctrl.rf_tsel;
    assign rf_o1sel   = ctrl.rf_o1sel;
    assign rf_o2sel   = ctrl.rf_o2sel;
    assign IR_enable  = ctrl.ir_enable;
    assign IR_lh      = ctrl.ir_lh;
    assign wrMEM      = ctrl.wr_mem;
    assign csMEM      = ctrl.cs_mem;
    assign MUXSelA    = ctrl.mux_a;
    assign MUXSelB    = ctrl.mux_b;
    assign MUXSelC    = ctrl.mux_c;
    assign halted     = ctrl.halted;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: drives reset/IR/flags per cycle and checks the full control word.
// Expected words are queued as stimulus is applied and compared at the falling edge.
// No backpressure involved; one check per clock cycle.
module tb_control_unit;

    localparam int PH_RST  = 0;
    localparam int PH_INIT = 1;
    localparam int PH_FL   = 2;
    localparam int PH_FH   = 3;
    localparam int PH_EX   = 4;
    localparam int PH_HLT  = 5;

    logic        clock;
    logic        reset_n;
    logic [15:0] ir_out;
    logic [3:0]  flags;
    logic [1:0]  outasel, outbsel, funsel_IR, funsel_arf, funsel_rf;
    logic [3:0]  funsel_alu, regsel_rf, regsel_arf, rf_tsel;
    logic [2:0]  rf_o1sel, rf_o2sel;
    logic        IR_enable, IR_lh, wrMEM, csMEM, MUXSelC, halted;
    logic [1:0]  MUXSelA, MUXSelB;

    int checks = 0;
    int errors = 0;

    logic [41:0] exp_q[$];
    string       tag_q[$];

    control_unit dut (
        .clock(clock), .reset_n(reset_n), .ir_out(ir_out), .flags(flags),
        .outasel(outasel), .outbsel(outbsel), .funsel_IR(funsel_IR),
        .funsel_arf(funsel_arf), .funsel_rf(funsel_rf), .funsel_alu(funsel_alu),
        .regsel_rf(regsel_rf), .regsel_arf(regsel_arf), .rf_tsel(rf_tsel),
        .rf_o1sel(rf_o1sel), .rf_o2sel(rf_o2sel), .IR_enable(IR_enable),
        .IR_lh(IR_lh), .wrMEM(wrMEM), .csMEM(csMEM), .MUXSelA(MUXSelA),
        .MUXSelB(MUXSelB), .MUXSelC(MUXSelC), .halted(halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [41:0] observed();
        return {outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu,
                regsel_rf, regsel_arf, rf_tsel, rf_o1sel, rf_o2sel,
                IR_enable, IR_lh, wrMEM, csMEM, MUXSelA, MUXSelB, MUXSelC, halted};
    endfunction

    // Reference control word for a cycle, written from the instruction-set table.
    function automatic logic [41:0] exp_word(input int ph, input logic [15:0] ir, input logic [3:0] fl);
        logic [1:0] oa, ob, fir, farf, frf, ma, mb;
        logic [3:0] falu, rrf, rarf, rt;
        logic [2:0] o1, o2;
        logic       ire, irl, wr, cs, mc, h, br;
        logic [1:0] rx, ry;
        oa = 0; ob = 0; fir = 2'b01; farf = 2'b01; frf = 2'b01; falu = 0;
        rrf = 0; rarf = 0; rt = 0; o1 = 0; o2 = 0; ire = 0; irl = 0;
        wr = 0; cs = 1; ma = 0; mb = 0; mc = 0; h = 0; br = 0;
        rx = ir[11:10]; ry = ir[9:8];
        case (ph)
            PH_INIT: begin
                rrf = 4'hF; rarf = 4'hF; rt = 4'hF; farf = 2'b00; frf = 2'b00;
                ire = 1; fir = 2'b00;
            end
            PH_FL, PH_FH: begin
                ob = 2'b11; cs = 0; ire = 1; irl = (ph == PH_FH); fir = 2'b01;
                rarf = 4'b0001; farf = 2'b11;
            end
            PH_EX: begin
                case (ir[15:12])
                    4'h0: begin ma = 2'b10; rrf = 4'b1000 >> rx; end
                    4'h1: begin ob = 2'b00; cs = 0; ma = 2'b01; rrf = 4'b1000 >> rx; end
                    4'h2: begin o1 = 3'b100 + 3'(rx); cs = 0; wr = 1; end
                    4'h3: begin
                        o1 = 3'b100 + 3'(rx); o2 = 3'b100 + 3'(ry);
                        falu = ir[7:4]; rrf = 4'b1000 >> rx;
                    end
                    4'h4: begin rrf = 4'b1000 >> rx; frf = 2'b11; end
                    4'h5: begin rrf = 4'b1000 >> rx; frf = 2'b10; end
                    4'h6: begin o1 = 3'b100 + 3'(rx); rarf = 4'b1000; end
                    4'h7: br = 1;
                    4'h8: br = fl[3];
                    4'h9: br = !fl[3];
                    default: ;
                endcase
                if (br) begin mb = 2'b10; rarf = 4'b0001; farf = 2'b01; end
            end
            PH_HLT: h = 1;
            default: ;
        endcase
        return {oa, ob, fir, farf, frf, falu, rrf, rarf, rt, o1, o2,
                ire, irl, wr, cs, ma, mb, mc, h};
    endfunction

    task automatic check_val(input string tag, input logic [41:0] got, input logic [41:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply reset level, queue expectation, compare at the falling edge.
    task automatic cyc(input string tag, input int ph, input logic rst_val);
        logic [41:0] e;
        string       t;
        reset_n = rst_val;
        exp_q.push_back(exp_word(rst_val ? ph : PH_RST, ir_out, flags));
        tag_q.push_back(tag);
        @(negedge clock);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_val(t, observed(), e);
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [15:0] ir, input logic [3:0] fl);
        flags = fl;
        cyc({tag, "_fl"}, PH_FL, 1'b1);
        cyc({tag, "_fh"}, PH_FH, 1'b1);
        ir_out = ir;
        cyc({tag, "_ex"}, PH_EX, 1'b1);
    endtask

    initial begin
        reset_n = 1'b0;
        ir_out  = 16'h0000;
        flags   = 4'h0;
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) cyc("reset_idle", PH_RST, 1'b0);
        cyc("init", PH_INIT, 1'b1);

        run_instr("ldi_r0_2a", 16'h002A, 4'h0);
        run_instr("ldi_r0_5",  16'h0005, 4'h0);
        run_instr("ldi_r1_3",  16'h0403, 4'h0);
        run_instr("alu_add",   16'h3140, 4'h0);
        run_instr("mva_r0",    16'h6000, 4'h0);
        run_instr("stm_r1",    16'h2400, 4'h0);
        run_instr("ldm_r3",    16'h1C00, 4'h0);
        run_instr("inc_r2",    16'h4800, 4'h0);
        run_instr("dec_r3",    16'h5C00, 4'h0);
        run_instr("beq_nt",    16'h8040, 4'b0000);
        run_instr("beq_t",     16'h8040, 4'b1000);
        run_instr("bne_t",     16'h9040, 4'b0111);
        run_instr("bne_nt",    16'h9040, 4'b1000);
        run_instr("bra",       16'h7010, 4'h0);
        run_instr("nop_a",     16'hA123, 4'h0);
        run_instr("nop_e",     16'hE0FF, 4'h0);

        // reset during FETCH_H: idle in reset cycle, INIT next
        cyc("mid_fl", PH_FL, 1'b1);
        cyc("mid_fh_rst", PH_FH, 1'b0);
        cyc("mid_init", PH_INIT, 1'b1);

        run_instr("hlt", 16'hF000, 4'h0);
        for (int i = 0; i < 12; i++) cyc("halted", PH_HLT, 1'b1);
        cyc("hlt_rst", PH_RST, 1'b0);
        cyc("hlt_init", PH_INIT, 1'b1);
        run_instr("post_ldi", 16'h0C7F, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer driving every control input of the `system` datapath: ARF, RF, IR, ALU, muxes A/B/C and memory. It fetches each 16-bit instruction as two bytes from memory at PC into IR, then decodes `ir_out` and executes the instruction in one cycle. It sits beside `system` as the initiator; `system` only responds to these signals.

## Interface
- No parameters.
- `clock  in  1`: rising-edge clock, shared with `system`.
- `reset_n  in  1`: synchronous reset, active-low.
- `ir_out  in  16`: full IR contents.
- `flags  in  4`: registered flags; [3]=Z, [2]=C, [1]=N, [0]=O.
- `outasel, outbsel  out  2`: ARF read selects; 00=AR, 01=SP, 10=PCP, 11=PC.
- `funsel_IR, funsel_arf, funsel_rf  out  2`: 00 clear, 01 load, 10 decrement, 11 increment.
- `funsel_alu  out  4`: ALU operation.
- `regsel_rf, regsel_arf, rf_tsel  out  4`: one-hot enables; bit3=R1/AR … bit0=R4/PC.
- `rf_o1sel, rf_o2sel  out  3`: RF read selects; Rn = 3'b100+n, n=0..3.
- `IR_enable, IR_lh  out  1`: IR write enable and byte select (0=low, 1=high).
- `wrMEM  out  1`: 1=write. `csMEM  out  1`: active-low chip select.
- `MUXSelA, MUXSelB  out  2`: 00 ALU, 01 MEM, 10 IR[7:0], 11 ARF outA.
- `MUXSelC  out  1`: 0 = RF o1, 1 = ARF outA.
- `halted  out  1`: high while in HALT.

## Operation
- **Default (idle) output values.** These hold in every state unless a state overrides them, and during reset:
  - all regsel/tsel = 0000; `IR_enable`=0; `csMEM`=1; `wrMEM`=0.
  - all funsel = 01; all selects = 0; `halted`=0.
- **States:** INIT → FETCH_L → FETCH_H → EXEC → FETCH_L; HLT is absorbing.
- **INIT** (one cycle after reset release): clear all registers.
  - `regsel_arf`=`regsel_rf`=`rf_tsel`=1111, funsel_arf/rf=00.
  - `IR_enable`=1, `funsel_IR`=00.
- **FETCH_L:** `outbsel`=11, `csMEM`=0, `IR_enable`=1, `IR_lh`=0, funsel_IR=01. Same cycle: `regsel_arf`=0001, funsel_arf=11 (PC++).
- **FETCH_H:** as FETCH_L with `IR_lh`=1.
- **EXEC:** decode fields as op=IR[15:12], x=IR[11:10], y=IR[9:8], imm=IR[7:0].
  - 0 LDI: Rx←imm. MUXSelA=10, regsel_rf=Rx, funsel_rf=01.
  - 1 LDM: Rx←M[AR]. outbsel=00, csMEM=0, MUXSelA=01, load Rx.
  - 2 STM: M[AR]←Rx. rf_o1sel=Rx, MUXSelC=0, funsel_alu=0000, outbsel=00, csMEM=0, wrMEM=1.
  - 3 ALU: Rx←f(Rx,Ry), f=IR[7:4].
    - rf_o1sel=Rx, rf_o2sel=Ry, MUXSelC=0, funsel_alu=IR[7:4], MUXSelA=00, load Rx.
  - 4 INC Rx (funsel_rf=11); 5 DEC Rx (funsel_rf=10).
  - 6 MVA: AR←Rx. ALU pass A (0000), MUXSelB=00, regsel_arf=1000, funsel_arf=01.
  - 7 BRA: PC←imm. MUXSelB=10, regsel_arf=0001, funsel_arf=01.
  - 8 BEQ: BRA if flags[3]=1, else idle outputs.
  - 9 BNE: BRA if flags[3]=0, else idle outputs.
  - F HLT: go to HLT.
  - A–E: NOP; idle outputs, continue to FETCH_L.
- **HLT:** idle outputs, `halted`=1; leave only via reset.
- **Register encoding:** Rn (n=0..3) → regsel_rf = 4'b1000>>n, o-select = 3'b100+n.

## Timing
- All outputs are combinational decodes of state and `ir_out`; the state register updates on the rising edge of `clock`.
- Instruction latency is 3 cycles (FETCH_L, FETCH_H, EXEC); the first fetch begins on the 2nd cycle after `reset_n` rises.
- PC increments at the end of each fetch cycle, so PC = instruction address + 2 during EXEC. Branch targets are absolute.
- BEQ/BNE sample `flags` during EXEC. These are flags registered by the previous instruction's EXEC edge.
- `reset_n`=0 at any edge, including mid-fetch or in HLT, forces INIT. While `reset_n`=0, outputs are the idle values, so no memory write and no register load occurs.
- PC wraps 0xFF→0x00 silently.

## Structure
- Shared package `cu_pkg`:
  - state enum {INIT, FETCH_L, FETCH_H, EXEC, HLT};
  - opcode constants OP_LDI … OP_HLT;
  - select constants SEL_AR/SP/PCP/PC and FS_CLR/LD/DEC/INC.
- One natural sub-module, `cu_decoder`: combinational op/x/y/flags → control word for EXEC. The FSM stays in `control_unit`.

## Test plan
- Reset:
  - Reset, then release → one INIT cycle with all regsel=1111 and funsel=00.
  - Next cycle is FETCH_L with outbsel=11, csMEM=0, IR_lh=0.
- LDI: program 0x0_0_00_2A (LDI R0, 0x2A) → R0=0x2A after 3 cycles.
  - regsel_rf=1000 and MUXSelA=10 in EXEC.
- Load, ALU, store: LDI R0,5; LDI R1,3; ALU R0,R1 with f=0100.
  - R0=0x08 and Z=0.
  - Then MVA/STM: wrMEM=1 and csMEM=0 for exactly one cycle.
- Branch:
  - BEQ to 0x40 with Z=0 → PC continues at +2.
  - With Z=1 → PC=0x40 on the following FETCH_L.
- HLT: `halted`=1 and outputs stay idle for 10+ cycles.
- Mid-operation reset: assert `reset_n`=0 during FETCH_H → INIT follows, and no IR load occurs in the reset cycle.
